// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the sequential execute-stage ALU.
//   - opcode encodings
//   - FSM state encoding
// Optional feature macro: ALU_SEQ_MUL_EN (enables the iterative multiply).
package alu_seq_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_AND = 4'b0000;
    localparam logic [OP_W-1:0] OP_OR  = 4'b0001;
    localparam logic [OP_W-1:0] OP_ADD = 4'b0010;
    localparam logic [OP_W-1:0] OP_SUB = 4'b0110;
    localparam logic [OP_W-1:0] OP_SLT = 4'b0111;
    localparam logic [OP_W-1:0] OP_NOR = 4'b1100;
    localparam logic [OP_W-1:0] OP_MUL = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_addsub.sv
// alu_addsub: combinational WIDTH-bit adder shared by ADD, SUB and SLT.
//   a, b     : operands
//   sub      : 1 -> a + ~b + 1, 0 -> a + b
//   sum      : WIDTH-bit result (mod 2^WIDTH)
//   cout     : carry out of the MSB
//   overflow : carry into MSB ^ carry out of MSB
module alu_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    logic [WIDTH-1:0] b_eff;
    // Low W-1 bits plus the carry into the MSB position in the top bit.
    logic [WIDTH-1:0] low;
    logic [1:0]       top;

    assign b_eff = sub ? ~b : b;
    assign low   = {1'b0, a[WIDTH-2:0]} + {1'b0, b_eff[WIDTH-2:0]}
                 + {{(WIDTH-1){1'b0}}, sub};
    assign top   = {1'b0, a[WIDTH-1]} + {1'b0, b_eff[WIDTH-1]} + {1'b0, low[WIDTH-1]};

    assign sum      = {top[0], low[WIDTH-2:0]};
    assign cout     = top[1];
    assign overflow = top[1] ^ low[WIDTH-1];

endmodule

// File: rtl/alu_seq.sv
// alu_seq: WIDTH-bit execute-stage ALU with valid/ready handshake.
//   Single-cycle ops: AND, OR, NOR, ADD, SUB, SLT. Optional iterative
//   unsigned shift-add MUL (WIDTH steps) when ALU_SEQ_MUL_EN is defined;
//   otherwise opcode 1000 is illegal and result_hi_o is tied to 0.
// Ports:
//   clk_i, rst_n              clock, synchronous active-low reset
//   in_valid_i/in_ready_o     request handshake (op_i, src1_i, src2_i)
//   out_valid_o/out_ready_i   result handshake
//   result_o, result_hi_o     result (low/high half of MUL product)
//   zero_o, cout_o, overflow_o, err_o   flags
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] result_hi_o,
    output logic             zero_o,
    output logic             cout_o,
    output logic             overflow_o,
    output logic             err_o
);

    state_t state_q, state_d;

    // in_ready is a register so it stays low through reset and rises on
    // the first edge after release, even though the state is already IDLE.
    logic rdy_q;
    logic accept;
    logic is_mul;
    logic load_single;

    logic [WIDTH-1:0] result_q;
    logic             zero_q, cout_q, ovf_q, err_q;

    // Single-cycle datapath
    logic             as_sub;
    logic [WIDTH-1:0] as_sum;
    logic             as_cout, as_ovf;
    logic [WIDTH-1:0] res_c;
    logic             cout_c, ovf_c, err_c;

    assign accept     = in_valid_i && rdy_q;
    assign in_ready_o = rdy_q;
    assign as_sub     = (op_i != OP_ADD);

    alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a        (src1_i),
        .b        (src2_i),
        .sub      (as_sub),
        .sum      (as_sum),
        .cout     (as_cout),
        .overflow (as_ovf)
    );

    always_comb begin
        res_c  = '0;
        cout_c = 1'b0;
        ovf_c  = 1'b0;
        err_c  = 1'b0;
        case (op_i)
            OP_AND: res_c = src1_i & src2_i;
            OP_OR:  res_c = src1_i | src2_i;
            OP_NOR: res_c = ~(src1_i | src2_i);
            OP_ADD, OP_SUB: begin
                res_c  = as_sum;
                cout_c = as_cout;
                ovf_c  = as_ovf;
            end
            OP_SLT: res_c = {{(WIDTH-1){1'b0}}, as_sum[WIDTH-1] ^ as_ovf};
            default: err_c = 1'b1;   // includes MUL, which never loads here when enabled
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH:0]     upper_sum;
    logic               mul_last;
    logic               mul_start;
    logic               mul_fin;
    logic [WIDTH-1:0]   result_hi_q;

    // prod_q = {accumulator, remaining multiplier bits}; each step adds the
    // multiplicand when the current LSB is set and shifts right by one, so
    // after WIDTH steps it holds the full product.
    assign upper_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                     + (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    assign prod_d    = {upper_sum, prod_q[WIDTH-1:1]};
    assign mul_last  = (cnt_q == CW'(WIDTH-1));
    assign is_mul    = (op_i == OP_MUL);

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
        end else if (mul_start) begin
            mcand_q <= src1_i;
            prod_q  <= {{WIDTH{1'b0}}, src2_i};
            cnt_q   <= '0;
        end else if (state_q == ST_BUSY) begin
            prod_q  <= prod_d;
            cnt_q   <= cnt_q + CW'(1);
        end
    end

    assign result_hi_o = result_hi_q;
`else
    assign is_mul      = 1'b0;
    assign result_hi_o = '0;
`endif

    // FSM: state register
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= (state_d == ST_IDLE);
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = is_mul ? ST_BUSY : ST_DONE;
`ifdef ALU_SEQ_MUL_EN
            ST_BUSY: if (mul_last) state_d = ST_DONE;
`endif
            ST_DONE: if (out_ready_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs / datapath strobes
    always_comb begin
        out_valid_o = (state_q == ST_DONE);
        load_single = accept && !is_mul;
`ifdef ALU_SEQ_MUL_EN
        mul_start   = accept && is_mul;
        mul_fin     = (state_q == ST_BUSY) && mul_last;
`endif
    end

    // Result/flag registers: written only on completion, so they stay
    // stable while the consumer back-pressures.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            result_q <= '0;
            zero_q   <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            result_hi_q <= '0;
`endif
        end else if (load_single) begin
            result_q <= res_c;
            zero_q   <= (res_c == '0);
            cout_q   <= cout_c;
            ovf_q    <= ovf_c;
            err_q    <= err_c;
`ifdef ALU_SEQ_MUL_EN
            result_hi_q <= '0;
`endif
        end
`ifdef ALU_SEQ_MUL_EN
        else if (mul_fin) begin
            // Final step's product goes straight to the output registers.
            result_q    <= prod_d[WIDTH-1:0];
            result_hi_q <= prod_d[2*WIDTH-1:WIDTH];
            zero_q      <= (prod_d[WIDTH-1:0] == '0);
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
        end
`endif
    end

    assign result_o   = result_q;
    assign zero_o     = zero_q;
    assign cout_o     = cout_q;
    assign overflow_o = ovf_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq (WIDTH = 32).
// A behavioural model tracks the handshake and expected outputs; one compare
// process checks the DUT against it on every negedge, plus literal
// expectations attached to directed operations.
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic z, c, v, e;
        int lat;
    } exp_t;

    typedef struct {
        string nm;
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic z, c, v, e;
        int lat;
    } lit_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] src1, src2;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result, result_hi;
    logic         zero, cout, overflow, err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk_i       (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .op_i        (op),
        .src1_i      (src1),
        .src2_i      (src2),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result),
        .result_hi_o (result_hi),
        .zero_o      (zero),
        .cout_o      (cout),
        .overflow_o  (overflow),
        .err_o       (err)
    );

    // ---------------- reference model ----------------
    function automatic exp_t calc(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t r;
        logic [W:0] s;
        logic [2*W-1:0] p;
        r = '{res: '0, hi: '0, z: 1'b0, c: 1'b0, v: 1'b0, e: 1'b0, lat: 1};
        case (o)
            4'b0000: r.res = a & b;
            4'b0001: r.res = a | b;
            4'b1100: r.res = ~(a | b);
            4'b0010: begin
                s = {1'b0, a} + {1'b0, b};
                r.res = s[W-1:0];
                r.c = s[W];
                r.v = (a[W-1] == b[W-1]) && (r.res[W-1] != a[W-1]);
            end
            4'b0110: begin
                s = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
                r.res = s[W-1:0];
                r.c = s[W];
                r.v = (a[W-1] != b[W-1]) && (r.res[W-1] != a[W-1]);
            end
            4'b0111: r.res = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
`ifdef ALU_SEQ_MUL_EN
            4'b1000: begin
                p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                r.res = p[W-1:0];
                r.hi = p[2*W-1:W];
                r.lat = W + 1;
            end
`endif
            default: r.e = 1'b1;
        endcase
        r.z = (r.res == '0);
        return r;
    endfunction

    exp_t m_new, m_out, m_pend;
    logic m_rdy = 1'b0, m_vld = 1'b0, m_clean = 1'b0, started = 1'b0;
    int   m_wait = 0, m_acc = 0, m_acc_cyc = 0, cyc = 0;
    int   m_tag = -1, m_ptag = -1, cur_lit = -1;
    lit_t lit_arr[10];

    always_comb m_new = calc(op, src1, src2);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            started <= 1'b1;
            m_rdy   <= 1'b0;
            m_vld   <= 1'b0;
            m_wait  <= 0;
            m_clean <= 1'b1;
            m_out   <= '{res: '0, hi: '0, z: 1'b0, c: 1'b0, v: 1'b0, e: 1'b0, lat: 0};
        end else if (m_wait > 0) begin
            if (m_wait == 1) begin
                m_vld  <= 1'b1;
                m_out  <= m_pend;
                m_tag  <= m_ptag;
                m_wait <= 0;
            end else begin
                m_wait <= m_wait - 1;
            end
        end else if (m_vld) begin
            if (out_ready) begin
                m_vld <= 1'b0;
                m_rdy <= 1'b1;
            end
        end else if (m_rdy && in_valid) begin
            m_rdy     <= 1'b0;
            m_acc     <= m_acc + 1;
            m_acc_cyc <= cyc;
            m_clean   <= 1'b0;
            if (m_new.lat == 1) begin
                m_vld <= 1'b1;
                m_out <= m_new;
                m_tag <= cur_lit;
            end else begin
                m_wait <= m_new.lat - 1;
                m_pend <= m_new;
                m_ptag <= cur_lit;
            end
        end else begin
            m_rdy <= 1'b1;
        end
    end

    // ---------------- compare process ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", nm, act, req, $time);
        end
    endtask

    logic prev_vld = 1'b0;

    always @(negedge clk) begin
        if (started) begin
            chk("in_ready", 64'(in_ready), 64'(m_rdy));
            chk("out_valid", 64'(out_valid), 64'(m_vld));
            if (m_vld || m_clean) begin
                chk("result", 64'(result), 64'(m_out.res));
                chk("result_hi", 64'(result_hi), 64'(m_out.hi));
                chk("flags_zcve", 64'({zero, cout, overflow, err}),
                    64'({m_out.z, m_out.c, m_out.v, m_out.e}));
            end
            if (m_vld && !prev_vld && m_tag >= 0) begin
                chk({lit_arr[m_tag].nm, "_dut_result"}, {result_hi, result},
                    {lit_arr[m_tag].hi, lit_arr[m_tag].res});
                chk({lit_arr[m_tag].nm, "_dut_flags"}, 64'({zero, cout, overflow, err}),
                    64'({lit_arr[m_tag].z, lit_arr[m_tag].c, lit_arr[m_tag].v, lit_arr[m_tag].e}));
                chk({lit_arr[m_tag].nm, "_model_result"}, {m_out.hi, m_out.res},
                    {lit_arr[m_tag].hi, lit_arr[m_tag].res});
                chk({lit_arr[m_tag].nm, "_model_flags"}, 64'({m_out.z, m_out.c, m_out.v, m_out.e}),
                    64'({lit_arr[m_tag].z, lit_arr[m_tag].c, lit_arr[m_tag].v, lit_arr[m_tag].e}));
                chk({lit_arr[m_tag].nm, "_latency"}, 64'(cyc - m_acc_cyc), 64'(lit_arr[m_tag].lat));
            end
            prev_vld <= m_vld;
        end
    end

    // ---------------- out_ready driver ----------------
    logic rr_rand = 1'b0, rr_force = 1'b1;

    always @(posedge clk) begin
        #1;
        out_ready = rr_rand ? 1'($urandom_range(0, 1)) : rr_force;
    end

    // ---------------- stimulus ----------------
    function automatic lit_t mk(input string nm, input logic [W-1:0] res, input logic [W-1:0] hi,
                                input logic z, input logic c, input logic v, input logic e, input int lat);
        lit_t l;
        l.nm = nm; l.res = res; l.hi = hi;
        l.z = z; l.c = c; l.v = v; l.e = e; l.lat = lat;
        return l;
    endfunction

    task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input int tag);
        int n0;
        int t;
        n0 = m_acc;
        t = 0;
        cur_lit = tag;
        op = o; src1 = a; src2 = b;
        in_valid = 1'b1;
        do begin
            @(posedge clk); #1;
            t++;
        end while (m_acc == n0 && t < 200);
        if (m_acc == n0) begin
            $display("FAIL accept_timeout actual=no_accept required=accept op=%0h", o);
            $fatal(1, "request never accepted");
        end
        in_valid = 1'b0;
        cur_lit = -1;
    endtask

    task automatic settle();
        int t;
        t = 0;
        while (!(m_rdy && !m_vld && m_wait == 0) && t < 400) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 400) begin
            $display("FAIL settle_timeout actual=busy required=idle");
            $fatal(1, "result never drained");
        end
    endtask

    function automatic logic [W-1:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return W'($urandom_range(0, 15));
            default: return W'($urandom);
        endcase
    endfunction

    logic [3:0] ops[8];

    initial begin
        ops = '{OP_AND, OP_OR, OP_NOR, OP_ADD, OP_SUB, OP_SLT, OP_MUL, OP_AND};
        lit_arr[0] = mk("add_ovf",  32'h8000_0000, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        lit_arr[1] = mk("sub_eq",   32'h0000_0000, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1);
        lit_arr[2] = mk("sub_neg",  32'hFFFF_FFFE, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        lit_arr[3] = mk("slt_lt",   32'h0000_0001, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        lit_arr[4] = mk("slt_ge",   32'h0000_0000, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        lit_arr[5] = mk("illegal_f", 32'h0000_0000, '0, 1'b1, 1'b0, 1'b0, 1'b1, 1);
`ifdef ALU_SEQ_MUL_EN
        lit_arr[6] = mk("mul_ff",   32'h0000_FE01, '0, 1'b0, 1'b0, 1'b0, 1'b0, W + 1);
        lit_arr[7] = mk("mul_max",  32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0, W + 1);
        lit_arr[8] = mk("mul_lozero", 32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 1'b0, W + 1);
`else
        lit_arr[6] = mk("op8_illegal", 32'h0000_0000, '0, 1'b1, 1'b0, 1'b0, 1'b1, 1);
`endif

        rst_n = 1'b0;
        in_valid = 1'b0;
        op = '0; src1 = '0; src2 = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        issue(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 0); settle();
        issue(OP_SUB, 32'd5, 32'd5, 1); settle();

        // Back-pressured SUB; a competing request while DONE must be ignored.
        rr_force = 1'b0;
        issue(OP_SUB, 32'd3, 32'd5, 2);
        op = OP_AND; src1 = 32'hDEAD_BEEF; src2 = 32'h1234_5678; in_valid = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        in_valid = 1'b0;
        rr_force = 1'b1;
        settle();

        issue(OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 3); settle();
        issue(OP_SLT, 32'h0000_0001, 32'hFFFF_FFFF, 4); settle();
        issue(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 5); settle();
`ifdef ALU_SEQ_MUL_EN
        issue(OP_MUL, 32'h0000_00FF, 32'h0000_00FF, 6); settle();
        issue(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 7); settle();
        issue(OP_MUL, 32'h0001_0000, 32'h0001_0000, 8); settle();
        // Reset while the multiply is iterating: no result may appear.
        issue(OP_MUL, 32'h0000_1234, 32'h0000_5678, -1);
        repeat (5) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (W + 8) begin @(posedge clk); #1; end
`else
        issue(OP_MUL, 32'h0000_00FF, 32'h0000_00FF, 6); settle();
`endif

        rr_rand = 1'b1;
        for (int i = 0; i < 300; i++) begin
            int k;
            logic [3:0] o;
            k = $urandom_range(0, 7);
            o = (k == 7) ? 4'($urandom) : ops[k];
            issue(o, rnd_opnd(), rnd_opnd(), -1);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        rr_rand = 1'b0;
        settle();
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
